pzcorebus_fifo: RTL

- Single-clock corebus buffer with three independent channel FIFOs: command (slave→master), write data (slave→master) and response (master→slave).
- Each channel has its own depth and an almost-full threshold. A depth of 0 turns that channel into a combinational bypass.
- Exports per-channel occupancy and status.
- Placed between a corebus master and slave in the same clock domain to decouple backpressure and absorb bursts.

---
 rtl/pzcorebus_fifo_if.sv | 54 +++++
 rtl/pzcorebus_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pzcorebus_fifo_if.sv
// Corebus configuration package and the pzcorebus_if bundle shared by pzcorebus_fifo and its neighbours.
// A zero width field in pzcorebus_config selects that channel's default payload width.
package pzcorebus_pkg;
    typedef struct packed {
        logic       csr_profile;
        logic [7:0] command_width;
        logic [7:0] data_width;
        logic [7:0] response_width;
    } pzcorebus_config;

    function automatic int get_command_width(pzcorebus_config cfg);
        return (cfg.command_width == 8'd0) ? 40 : int'(cfg.command_width);
    endfunction

    function automatic int get_data_width(pzcorebus_config cfg);
        return (cfg.data_width == 8'd0) ? 32 : int'(cfg.data_width);
    endfunction

    function automatic int get_response_width(pzcorebus_config cfg);
        return (cfg.response_width == 8'd0) ? 40 : int'(cfg.response_width);
    endfunction

    function automatic bit is_memory_profile(pzcorebus_config cfg);
        return !cfg.csr_profile;
    endfunction
endpackage

interface pzcorebus_if #(
    parameter pzcorebus_pkg::pzcorebus_config BUS_CONFIG = '0
);
    localparam int COMMAND_WIDTH  = pzcorebus_pkg::get_command_width(BUS_CONFIG);
    localparam int DATA_WIDTH     = pzcorebus_pkg::get_data_width(BUS_CONFIG);
    localparam int RESPONSE_WIDTH = pzcorebus_pkg::get_response_width(BUS_CONFIG);

    logic                      mcmd_valid;
    logic                      scmd_accept;
    logic [COMMAND_WIDTH-1:0]  mcmd;
    logic                      mdata_valid;
    logic                      sdata_accept;
    logic [DATA_WIDTH-1:0]     mdata;
    logic                      sresp_valid;
    logic                      mresp_accept;
    logic [RESPONSE_WIDTH-1:0] sresp;

    modport master (
        output mcmd_valid, mcmd, mdata_valid, mdata, mresp_accept,
        input  scmd_accept, sdata_accept, sresp_valid, sresp
    );

    modport slave (
        input  mcmd_valid, mcmd, mdata_valid, mdata, mresp_accept,
        output scmd_accept, sdata_accept, sresp_valid, sresp
    );
endinterface

// File: rtl/pzcorebus_fifo.sv
// Corebus buffer with independent command, write-data and response FIFOs (depth 0 = wire bypass).
// Optional peak-occupancy tracking is built when PZCOREBUS_FIFO_WATERMARK_EN is defined.
module pzcorebus_fifo_channel #(
    parameter int DEPTH     = 2,
    parameter int THRESHOLD = DEPTH,
    parameter int WIDTH     = 8,
    parameter int CNT_W     = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_accept,
    input  logic [WIDTH-1:0] i_payload,
    output logic             o_valid,
    input  logic             i_accept,
    output logic [WIDTH-1:0] o_payload,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_almost_full,
    output logic             o_full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    if (DEPTH == 0) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = i_clk ^ i_rst_n;
        assign o_valid       = i_valid;
        assign o_payload     = i_payload;
        assign o_accept      = i_accept;
        assign o_count       = '0;
        assign o_empty       = 1'b1;
        assign o_almost_full = 1'b0;
        assign o_full        = 1'b0;
    end else begin : g_fifo
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0] wptr_q;
        logic [PTR_W-1:0] rptr_q;
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] count_d;
        logic             almost_full_q;
        logic             push;
        logic             pop;

        // Accept and valid come only from registered state, so a full FIFO cannot push through.
        assign o_full        = (count_q == CNT_W'(DEPTH));
        assign o_empty       = (count_q == '0);
        assign o_accept      = i_rst_n && !o_full;
        assign o_valid       = !o_empty;
        assign o_payload     = mem_q[rptr_q];
        assign o_count       = count_q;
        assign o_almost_full = almost_full_q;
        assign push          = i_valid && o_accept;
        assign pop           = o_valid && i_accept;

        always_comb begin
            count_d = count_q;
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                wptr_q        <= '0;
                rptr_q        <= '0;
                count_q       <= '0;
                almost_full_q <= 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else begin
                if (push) begin
                    mem_q[wptr_q] <= i_payload;
                    wptr_q        <= next_ptr(wptr_q);
                end
                if (pop) begin
                    rptr_q <= next_ptr(rptr_q);
                end
                count_q       <= count_d;
                almost_full_q <= (count_d >= CNT_W'(THRESHOLD));
            end
        end
    end
endmodule

module pzcorebus_fifo
    import pzcorebus_pkg::*;
#(
    parameter pzcorebus_config BUS_CONFIG         = '0,
    parameter int              COMMAND_DEPTH      = 2,
    parameter int              DATA_DEPTH         = 2,
    parameter int              RESPONSE_DEPTH     = 2,
    parameter int              COMMAND_THRESHOLD  = COMMAND_DEPTH,
    parameter int              DATA_THRESHOLD     = DATA_DEPTH,
    parameter int              RESPONSE_THRESHOLD = RESPONSE_DEPTH,
    parameter bit              SVA_CHECKER        = 1'b1,
    localparam int CMD_CNT_W  = (COMMAND_DEPTH == 0) ? 1 : $clog2(COMMAND_DEPTH + 1),
    localparam int DATA_CNT_W = (DATA_DEPTH == 0) ? 1 : $clog2(DATA_DEPTH + 1),
    localparam int RESP_CNT_W = (RESPONSE_DEPTH == 0) ? 1 : $clog2(RESPONSE_DEPTH + 1)
`ifdef PZCOREBUS_FIFO_WATERMARK_EN
    ,
    localparam int MAX_DEPTH = (COMMAND_DEPTH > DATA_DEPTH)
        ? ((COMMAND_DEPTH > RESPONSE_DEPTH) ? COMMAND_DEPTH : RESPONSE_DEPTH)
        : ((DATA_DEPTH > RESPONSE_DEPTH) ? DATA_DEPTH : RESPONSE_DEPTH),
    localparam int WM_W = (MAX_DEPTH == 0) ? 1 : $clog2(MAX_DEPTH + 1)
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    pzcorebus_if.slave            slave_if,
    pzcorebus_if.master           master_if,
    output logic [2:0]            o_empty,
    output logic [2:0]            o_almost_full,
    output logic [2:0]            o_full,
    output logic [CMD_CNT_W-1:0]  o_command_count,
    output logic [DATA_CNT_W-1:0] o_data_count,
    output logic [RESP_CNT_W-1:0] o_response_count
`ifdef PZCOREBUS_FIFO_WATERMARK_EN
    ,
    input  logic                  i_watermark_clear,
    output logic [3*WM_W-1:0]     o_watermark
`endif
);
    localparam int CMD_W  = get_command_width(BUS_CONFIG);
    localparam int DATA_W = get_data_width(BUS_CONFIG);
    localparam int RESP_W = get_response_width(BUS_CONFIG);

    logic cmd_empty, cmd_afull, cmd_full;
    logic data_empty, data_afull, data_full;
    logic resp_empty, resp_afull, resp_full;

    pzcorebus_fifo_channel #(
        .DEPTH(COMMAND_DEPTH), .THRESHOLD(COMMAND_THRESHOLD), .WIDTH(CMD_W), .CNT_W(CMD_CNT_W)
    ) u_command (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(slave_if.mcmd_valid), .o_accept(slave_if.scmd_accept), .i_payload(slave_if.mcmd),
        .o_valid(master_if.mcmd_valid), .i_accept(master_if.scmd_accept), .o_payload(master_if.mcmd),
        .o_count(o_command_count), .o_empty(cmd_empty), .o_almost_full(cmd_afull), .o_full(cmd_full)
    );

    // Write data only travels on memory-profile buses.
    if (is_memory_profile(BUS_CONFIG)) begin : g_data
        pzcorebus_fifo_channel #(
            .DEPTH(DATA_DEPTH), .THRESHOLD(DATA_THRESHOLD), .WIDTH(DATA_W), .CNT_W(DATA_CNT_W)
        ) u_data (
            .i_clk(i_clk), .i_rst_n(i_rst_n),
            .i_valid(slave_if.mdata_valid), .o_accept(slave_if.sdata_accept), .i_payload(slave_if.mdata),
            .o_valid(master_if.mdata_valid), .i_accept(master_if.sdata_accept), .o_payload(master_if.mdata),
            .o_count(o_data_count), .o_empty(data_empty), .o_almost_full(data_afull), .o_full(data_full)
        );
    end else begin : g_no_data
        logic unused_data;
        assign unused_data            = ^{slave_if.mdata_valid, slave_if.mdata, master_if.sdata_accept};
        assign slave_if.sdata_accept  = 1'b0;
        assign master_if.mdata_valid  = 1'b0;
        assign master_if.mdata        = '0;
        assign o_data_count           = '0;
        assign data_empty             = 1'b1;
        assign data_afull             = 1'b0;
        assign data_full              = 1'b0;
    end

    pzcorebus_fifo_channel #(
        .DEPTH(RESPONSE_DEPTH), .THRESHOLD(RESPONSE_THRESHOLD), .WIDTH(RESP_W), .CNT_W(RESP_CNT_W)
    ) u_response (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_valid(master_if.sresp_valid), .o_accept(master_if.mresp_accept), .i_payload(master_if.sresp),
        .o_valid(slave_if.sresp_valid), .i_accept(slave_if.mresp_accept), .o_payload(slave_if.sresp),
        .o_count(o_response_count), .o_empty(resp_empty), .o_almost_full(resp_afull), .o_full(resp_full)
    );

    assign o_empty       = {resp_empty, data_empty, cmd_empty};
    assign o_almost_full = {resp_afull, data_afull, cmd_afull};
    assign o_full        = {resp_full, data_full, cmd_full};

`ifdef PZCOREBUS_FIFO_WATERMARK_EN
    logic [WM_W-1:0] count_ext   [3];
    logic [WM_W-1:0] watermark_q [3];

    assign count_ext[0] = WM_W'(o_command_count);
    assign count_ext[1] = WM_W'(o_data_count);
    assign count_ext[2] = WM_W'(o_response_count);

    // Tracks the registered count, so the peak lands one cycle after the count moves.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!i_rst_n) begin
                watermark_q[i] <= '0;
            end else if (i_watermark_clear || (count_ext[i] > watermark_q[i])) begin
                watermark_q[i] <= count_ext[i];
            end
        end
    end

    assign o_watermark = {watermark_q[2], watermark_q[1], watermark_q[0]};
`endif

    if (SVA_CHECKER && (COMMAND_DEPTH > 0)) begin : g_sva_cmd
        assert property (@(posedge i_clk) disable iff (!i_rst_n)
            (master_if.mcmd_valid && !master_if.scmd_accept)
                |=> (master_if.mcmd_valid && $stable(master_if.mcmd)));
    end
    if (SVA_CHECKER && (DATA_DEPTH > 0)) begin : g_sva_data
        assert property (@(posedge i_clk) disable iff (!i_rst_n)
            (master_if.mdata_valid && !master_if.sdata_accept)
                |=> (master_if.mdata_valid && $stable(master_if.mdata)));
    end
    if (SVA_CHECKER && (RESPONSE_DEPTH > 0)) begin : g_sva_resp
        assert property (@(posedge i_clk) disable iff (!i_rst_n)
            (slave_if.sresp_valid && !slave_if.mresp_accept)
                |=> (slave_if.sresp_valid && $stable(slave_if.sresp)));
    end
endmodule
